decode_writeback: RTL and testbench
===================================

Name: decode_writeback

Overview:
- Y86-64 SEQ decode/writeback stage, holding the 15-entry register file.
- Decode side: drives valA/valB into execute and memory.
- Writeback side: commits valE (from execute) and valM (from memory) at the clock edge.
- Also owns the sticky processor status (Stat) and a retired-instruction counter, which the top-level testbench monitors for halt.

Parameters:
- WIDTH, 64, data width of registers, valE, valM, valA, valB.
- NREGS, 15, architectural registers (IDs 0..14); ID 4'hF = "none".
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- instr_valid  input  1  current icode/operands/values are final; commit only when high.
- icode  input  4  instruction code from fetch.
- ra  input  4  rA field from fetch.
- rb  input  4  rB field from fetch.
- cnd  input  1  condition result from execute (cmovXX).
- valE  input  WIDTH  ALU result.
- valM  input  WIDTH  memory read data.
- mem_err  input  1  memory address error.
- instruct_err  input  1  invalid instruction / fetch error.
- valA  output  WIDTH  register read port A.
- valB  output  WIDTH  register read port B.
- stat  output  2  00 AOK, 01 HLT, 10 ADR, 11 INS.
- halted  output  1  high when stat != AOK.
- retired  output  CNT_W  count of committed instructions.

Behaviour:
- Reset (async, rst_n=0): all registers 0, stat=AOK, retired=0; halted=0, valA=valB=0 combinationally.
- srcA selection:
  - ra for icode 2,4,6,A.
  - 4 (%rsp) for icode 9,B.
  - else F.
- srcB selection:
  - rb for icode 4,5,6.
  - 4 for icode 8,9,A,B.
  - else F.
- dstE selection:
  - rb for icode 3,6.
  - icode 2: rb if cnd else F.
  - 4 for icode 8,9,A,B.
  - else F.
- dstM selection: ra for icode 5,B; else F.
- Reads are combinational; source F reads 0.
- Commit condition: posedge clk with instr_valid=1 and stat==AOK.
  - Status first: instruct_err, else mem_err, else icode==0. Matching the first sets stat to INS, ADR or HLT respectively; no register write; retired unchanged.
  - Otherwise: write R[dstE]<=valE if dstE!=F; write R[dstM]<=valM if dstM!=F; retired+=1.
  - dstE==dstM (popq %rsp): valM wins.
- Once stat != AOK it is sticky until reset: no writes, counter frozen, inputs ignored.
- instr_valid=0: no state change (stall).
- Same-cycle read of a register being written returns the old value (SEQ semantics).
- retired wraps modulo 2^CNT_W.
- Reset asserted mid-cycle clears state immediately; first commit occurs at the first posedge after rst_n rises.

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN.
- Defined: valA/valB forward the pending valM (priority) or valE when the source matches dstM/dstE and a commit is enabled this cycle. Intended for the future PIPE reuse.
- Undefined: no bypass; reads always return stored values.

Decomposition:
- Shared package y86_pkg: icode constants (IHALT..IPOPQ), RRSP=4, RNONE=4'hF, stat encodings SAOK/SHLT/SADR/SINS.
- One natural sub-module: regfile_2r2w (2 combinational read ports, 2 write ports with port-M priority, async reset). Register-ID selection, status and counter logic stay in decode_writeback.

Test Plan:
- Reset then irmovq (icode 3, rb=3, valE=6, valid) -> R3=6 next edge, retired=1, stat=AOK.
- cmov: icode 2, ra=3, rb=2, cnd=0 -> valA=6, R2 unchanged. Same with cnd=1 -> R2=6, retired increments.
- popq %rsp: icode B, ra=4, valE=0x100, valM=0x55 -> R4=0x55, valB before edge reads old R4.
- mem_err=1 on mrmovq -> stat=ADR, halted=1, no write. Subsequent irmovq to R5 -> ignored, retired frozen.
- halt (icode 0) -> stat=HLT; instr_valid=0 cycles beforehand leave registers and counter unchanged.
- rst_n pulsed low mid-cycle after halt -> stat=AOK, all registers 0, retired=0 immediately. With DECODE_WB_BYPASS_EN: OPq writing R1 while reading R1 -> valA=new valE.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, special register IDs and
// processor status values used by the decode/writeback slice.
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Register IDs with special meaning
    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    // Processor status
    typedef enum logic [1:0] {
        SAOK = 2'b00,
        SHLT = 2'b01,
        SADR = 2'b10,
        SINS = 2'b11
    } stat_e;

endpackage

// File: rtl/regfile_2r2w.sv
// Register file with two combinational read ports and two write ports
// (E and M). When both write ports target the same register, port M wins.
// Reading an ID outside the implemented range (e.g. 4'hF) returns zero.
module regfile_2r2w #(
    parameter int WIDTH = 64,
    parameter int NREGS = 15,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    i_rd_addr_a,
    output logic [WIDTH-1:0] o_rd_data_a,
    input  logic [AW-1:0]    i_rd_addr_b,
    output logic [WIDTH-1:0] o_rd_data_b,
    input  logic             i_we_e,
    input  logic [AW-1:0]    i_wr_addr_e,
    input  logic [WIDTH-1:0] i_wr_data_e,
    input  logic             i_we_m,
    input  logic [AW-1:0]    i_wr_addr_m,
    input  logic [WIDTH-1:0] i_wr_data_m
);

    localparam logic [AW-1:0] LAST_ID = AW'(NREGS - 1);

    logic [WIDTH-1:0] r_regs [NREGS];

    // Combinational read ports; unimplemented IDs read as zero
    always_comb begin
        o_rd_data_a = '0;
        o_rd_data_b = '0;
        if (i_rd_addr_a <= LAST_ID) o_rd_data_a = r_regs[i_rd_addr_a];
        if (i_rd_addr_b <= LAST_ID) o_rd_data_b = r_regs[i_rd_addr_b];
    end

    // Register storage: async clear, port M has priority over port E
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (i_we_m && (i_wr_addr_m == AW'(i)))
                    r_regs[i] <= i_wr_data_m;
                else if (i_we_e && (i_wr_addr_e == AW'(i)))
                    r_regs[i] <= i_wr_data_e;
            end
        end
    end

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode/writeback stage: register ID selection, register file,
// sticky processor status and retired-instruction counter.
// Optional macro DECODE_WB_BYPASS_EN forwards the pending valM/valE onto
// valA/valB when the read source matches a register being committed.
module decode_writeback
    import y86_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int NREGS = 15,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    input  logic [3:0]       icode,
    input  logic [3:0]       ra,
    input  logic [3:0]       rb,
    input  logic             cnd,
    input  logic [WIDTH-1:0] valE,
    input  logic [WIDTH-1:0] valM,
    input  logic             mem_err,
    input  logic             instruct_err,
    output logic [WIDTH-1:0] valA,
    output logic [WIDTH-1:0] valB,
    output logic [1:0]       stat,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    stat_e            r_stat;
    logic [CNT_W-1:0] r_retired;

    logic [3:0]       w_src_a;
    logic [3:0]       w_src_b;
    logic [3:0]       w_dst_e;
    logic [3:0]       w_dst_m;
    logic             w_commit;
    logic             w_wr;
    logic             w_we_e;
    logic             w_we_m;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;

    // Register ID selection from icode and operand fields
    always_comb begin
        w_src_a = RNONE;
        w_src_b = RNONE;
        w_dst_e = RNONE;
        w_dst_m = RNONE;
        case (icode)
            IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: w_src_a = ra;
            IRET, IPOPQ:                    w_src_a = RRSP;
            default:                        w_src_a = RNONE;
        endcase
        case (icode)
            IRMMOVQ, IMRMOVQ, IOPQ:         w_src_b = rb;
            ICALL, IRET, IPUSHQ, IPOPQ:     w_src_b = RRSP;
            default:                        w_src_b = RNONE;
        endcase
        case (icode)
            IIRMOVQ, IOPQ:                  w_dst_e = rb;
            IRRMOVQ:                        w_dst_e = cnd ? rb : RNONE;
            ICALL, IRET, IPUSHQ, IPOPQ:     w_dst_e = RRSP;
            default:                        w_dst_e = RNONE;
        endcase
        case (icode)
            IMRMOVQ, IPOPQ:                 w_dst_m = ra;
            default:                        w_dst_m = RNONE;
        endcase
    end

    // A commit is only considered while the processor is still running;
    // an error or halt takes the status path and suppresses all writes.
    assign w_commit = instr_valid && (r_stat == SAOK);
    assign w_wr     = w_commit && !instruct_err && !mem_err && (icode != IHALT);
    assign w_we_e   = w_wr && (w_dst_e != RNONE);
    assign w_we_m   = w_wr && (w_dst_m != RNONE);

    regfile_2r2w #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .AW    (4)
    ) u_regfile (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rd_addr_a (w_src_a),
        .o_rd_data_a (w_rd_a),
        .i_rd_addr_b (w_src_b),
        .o_rd_data_b (w_rd_b),
        .i_we_e      (w_we_e),
        .i_wr_addr_e (w_dst_e),
        .i_wr_data_e (valE),
        .i_we_m      (w_we_m),
        .i_wr_addr_m (w_dst_m),
        .i_wr_data_m (valM)
    );

`ifdef DECODE_WB_BYPASS_EN
    // Read ports with forwarding of the value being committed this cycle
    always_comb begin
        valA = w_rd_a;
        valB = w_rd_b;
        if (w_we_m && (w_src_a == w_dst_m))      valA = valM;
        else if (w_we_e && (w_src_a == w_dst_e)) valA = valE;
        if (w_we_m && (w_src_b == w_dst_m))      valB = valM;
        else if (w_we_e && (w_src_b == w_dst_e)) valB = valE;
    end
`else
    // Read ports return stored values; writes become visible next cycle
    always_comb begin
        valA = w_rd_a;
        valB = w_rd_b;
    end
`endif

    // Sticky status: first fault or halt seen while running is latched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat <= SAOK;
        end else if (w_commit) begin
            if (instruct_err)        r_stat <= SINS;
            else if (mem_err)        r_stat <= SADR;
            else if (icode == IHALT) r_stat <= SHLT;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= '0;
        end else if (w_wr) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign stat    = r_stat;
    assign halted  = (r_stat != SAOK);
    assign retired = r_retired;

endmodule

// File: tb/tb_decode_writeback.sv
// Directed testbench for decode_writeback. Registers are observed through
// the read ports by presenting an OPq (icode 6) with instr_valid low.
module tb_decode_writeback;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [3:0]  icode;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        mem_err;
    logic        instruct_err;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [1:0]  stat;
    logic        halted;
    logic [31:0] retired;

    int checks   = 0;
    int failures = 0;

    decode_writeback #(
        .WIDTH (64),
        .NREGS (15),
        .CNT_W (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .icode        (icode),
        .ra           (ra),
        .rb           (rb),
        .cnd          (cnd),
        .valE         (valE),
        .valM         (valM),
        .mem_err      (mem_err),
        .instruct_err (instruct_err),
        .valA         (valA),
        .valB         (valB),
        .stat         (stat),
        .halted       (halted),
        .retired      (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                         input logic c, input logic [63:0] e, input logic [63:0] m,
                         input logic me, input logic ie, input logic v);
        icode        = ic;
        ra           = a;
        rb           = b;
        cnd          = c;
        valE         = e;
        valM         = m;
        mem_err      = me;
        instruct_err = ie;
        instr_valid  = v;
        #1;
    endtask

    task automatic rd(input logic [3:0] a, input logic [3:0] b);
        drive(4'h6, a, b, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++; if (stat !== 2'b00) begin failures++; $display("FAIL reset_stat got=%0d exp=0", stat); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%0d exp=0", halted); end
        checks++; if (retired !== 32'd0) begin failures++; $display("FAIL reset_retired got=%0d exp=0", retired); end
        rd(4'd3, 4'd4);
        checks++; if (valA !== 64'h0) begin failures++; $display("FAIL reset_valA got=%h exp=0", valA); end
        checks++; if (valB !== 64'h0) begin failures++; $display("FAIL reset_valB got=%h exp=0", valB); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_irmovq();
        drive(4'h3, 4'hF, 4'd3, 1'b0, 64'd6, 64'h0, 1'b0, 1'b0, 1'b1);
        step();
        rd(4'd3, 4'd3);
        checks++; if (valA !== 64'd6) begin failures++; $display("FAIL irmovq_R3 got=%h exp=6", valA); end
        checks++; if (retired !== 32'd1) begin failures++; $display("FAIL irmovq_retired got=%0d exp=1", retired); end
        checks++; if (stat !== 2'b00) begin failures++; $display("FAIL irmovq_stat got=%0d exp=0", stat); end
    endtask

    task automatic test_cmov();
        drive(4'h2, 4'd3, 4'd2, 1'b0, 64'd6, 64'h0, 1'b0, 1'b0, 1'b1);
        checks++; if (valA !== 64'd6) begin failures++; $display("FAIL cmov_valA got=%h exp=6", valA); end
        step();
        rd(4'd2, 4'd2);
        checks++; if (valA !== 64'd0) begin failures++; $display("FAIL cmov_nc_R2 got=%h exp=0", valA); end
        checks++; if (retired !== 32'd2) begin failures++; $display("FAIL cmov_nc_retired got=%0d exp=2", retired); end
        drive(4'h2, 4'd3, 4'd2, 1'b1, 64'd6, 64'h0, 1'b0, 1'b0, 1'b1);
        step();
        rd(4'd2, 4'd2);
        checks++; if (valA !== 64'd6) begin failures++; $display("FAIL cmov_c_R2 got=%h exp=6", valA); end
        checks++; if (retired !== 32'd3) begin failures++; $display("FAIL cmov_c_retired got=%0d exp=3", retired); end
    endtask

    task automatic test_popq();
        logic [63:0] exp_b;
`ifdef DECODE_WB_BYPASS_EN
        exp_b = 64'h55;
`else
        exp_b = 64'h200;
`endif
        drive(4'h3, 4'hF, 4'd4, 1'b0, 64'h200, 64'h0, 1'b0, 1'b0, 1'b1);
        step();
        drive(4'hB, 4'd4, 4'hF, 1'b0, 64'h100, 64'h55, 1'b0, 1'b0, 1'b1);
        checks++; if (valB !== exp_b) begin failures++; $display("FAIL popq_rsp_valB got=%h exp=%h", valB, exp_b); end
        step();
        rd(4'd4, 4'd4);
        checks++; if (valA !== 64'h55) begin failures++; $display("FAIL popq_rsp_R4 got=%h exp=55", valA); end
        checks++; if (retired !== 32'd5) begin failures++; $display("FAIL popq_rsp_retired got=%0d exp=5", retired); end
        drive(4'hB, 4'd7, 4'hF, 1'b0, 64'h108, 64'h77, 1'b0, 1'b0, 1'b1);
        step();
        rd(4'd4, 4'd7);
        checks++; if (valA !== 64'h108) begin failures++; $display("FAIL popq_R4 got=%h exp=108", valA); end
        checks++; if (valB !== 64'h77) begin failures++; $display("FAIL popq_R7 got=%h exp=77", valB); end
        checks++; if (retired !== 32'd6) begin failures++; $display("FAIL popq_retired got=%0d exp=6", retired); end
    endtask

    task automatic test_opq();
        logic [63:0] exp_a;
`ifdef DECODE_WB_BYPASS_EN
        exp_a = 64'h33;
`else
        exp_a = 64'h0;
`endif
        drive(4'h6, 4'd1, 4'd1, 1'b0, 64'h33, 64'h0, 1'b0, 1'b0, 1'b1);
        checks++; if (valA !== exp_a) begin failures++; $display("FAIL opq_same_cycle_valA got=%h exp=%h", valA, exp_a); end
        step();
        rd(4'd1, 4'd3);
        checks++; if (valA !== 64'h33) begin failures++; $display("FAIL opq_R1 got=%h exp=33", valA); end
        checks++; if (valB !== 64'd6) begin failures++; $display("FAIL opq_R3 got=%h exp=6", valB); end
        checks++; if (retired !== 32'd7) begin failures++; $display("FAIL opq_retired got=%0d exp=7", retired); end
    endtask

    task automatic test_stall();
        drive(4'h3, 4'hF, 4'd5, 1'b0, 64'h99, 64'h0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        step();
        rd(4'd5, 4'd5);
        checks++; if (valA !== 64'h0) begin failures++; $display("FAIL stall_R5 got=%h exp=0", valA); end
        checks++; if (retired !== 32'd7) begin failures++; $display("FAIL stall_retired got=%0d exp=7", retired); end
    endtask

    task automatic test_mem_err();
        drive(4'h5, 4'd6, 4'd3, 1'b0, 64'h0, 64'hAA, 1'b1, 1'b0, 1'b1);
        step();
        rd(4'd6, 4'd6);
        checks++; if (stat !== 2'b10) begin failures++; $display("FAIL memerr_stat got=%0d exp=2", stat); end
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL memerr_halted got=%0d exp=1", halted); end
        checks++; if (valA !== 64'h0) begin failures++; $display("FAIL memerr_R6 got=%h exp=0", valA); end
        checks++; if (retired !== 32'd7) begin failures++; $display("FAIL memerr_retired got=%0d exp=7", retired); end
        drive(4'h3, 4'hF, 4'd5, 1'b0, 64'h5, 64'h0, 1'b0, 1'b0, 1'b1);
        step();
        rd(4'd5, 4'd5);
        checks++; if (valA !== 64'h0) begin failures++; $display("FAIL sticky_R5 got=%h exp=0", valA); end
        checks++; if (retired !== 32'd7) begin failures++; $display("FAIL sticky_retired got=%0d exp=7", retired); end
        checks++; if (stat !== 2'b10) begin failures++; $display("FAIL sticky_stat got=%0d exp=2", stat); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (stat !== 2'b00) begin failures++; $display("FAIL midrst_stat got=%0d exp=0", stat); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL midrst_halted got=%0d exp=0", halted); end
        checks++; if (retired !== 32'd0) begin failures++; $display("FAIL midrst_retired got=%0d exp=0", retired); end
        rd(4'd3, 4'd4);
        checks++; if (valA !== 64'h0) begin failures++; $display("FAIL midrst_R3 got=%h exp=0", valA); end
        checks++; if (valB !== 64'h0) begin failures++; $display("FAIL midrst_R4 got=%h exp=0", valB); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'h3, 4'hF, 4'd2, 1'b0, 64'h11, 64'h0, 1'b0, 1'b0, 1'b1);
        step();
        rd(4'd2, 4'd2);
        checks++; if (valA !== 64'h11) begin failures++; $display("FAIL postrst_R2 got=%h exp=11", valA); end
        checks++; if (retired !== 32'd1) begin failures++; $display("FAIL postrst_retired got=%0d exp=1", retired); end
    endtask

    task automatic test_halt();
        drive(4'h6, 4'd2, 4'd2, 1'b0, 64'h44, 64'h0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        rd(4'd2, 4'd2);
        checks++; if (valA !== 64'h11) begin failures++; $display("FAIL prehalt_R2 got=%h exp=11", valA); end
        checks++; if (retired !== 32'd1) begin failures++; $display("FAIL prehalt_retired got=%0d exp=1", retired); end
        drive(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1);
        step();
        rd(4'd2, 4'd2);
        checks++; if (stat !== 2'b01) begin failures++; $display("FAIL halt_stat got=%0d exp=1", stat); end
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_halted got=%0d exp=1", halted); end
        checks++; if (retired !== 32'd1) begin failures++; $display("FAIL halt_retired got=%0d exp=1", retired); end
        checks++; if (valA !== 64'h11) begin failures++; $display("FAIL halt_R2 got=%h exp=11", valA); end
    endtask

    task automatic test_ins_priority();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        drive(4'h3, 4'hF, 4'd3, 1'b0, 64'h9, 64'h0, 1'b1, 1'b1, 1'b1);
        step();
        rd(4'd3, 4'd3);
        checks++; if (stat !== 2'b11) begin failures++; $display("FAIL ins_stat got=%0d exp=3", stat); end
        checks++; if (retired !== 32'd0) begin failures++; $display("FAIL ins_retired got=%0d exp=0", retired); end
        checks++; if (valA !== 64'h0) begin failures++; $display("FAIL ins_R3 got=%h exp=0", valA); end
    endtask

    initial begin
        rst_n        = 1'b1;
        instr_valid  = 1'b0;
        icode        = 4'h1;
        ra           = 4'hF;
        rb           = 4'hF;
        cnd          = 1'b0;
        valE         = 64'h0;
        valM         = 64'h0;
        mem_err      = 1'b0;
        instruct_err = 1'b0;
        test_reset();
        test_irmovq();
        test_cmov();
        test_popq();
        test_opq();
        test_stall();
        test_mem_err();
        test_reset_mid();
        test_halt();
        test_ins_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
